// File: rtl/seq_display_monitor.sv
// Two-digit 7-segment display monitor.
// Debounces the {tens, units} glyph pair and decodes it to a number. The
// number is tracked around the ring 5,10,15,4,9,14,3,8. The block reports
// position, direction and step pulses, along with step-rate, error and
// timeout status.

module seq_display_monitor #(
    parameter int fpga_f     = 50_000_000,
    parameter int n          = 4,
    parameter int stable_cyc = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [6:0]   seg1,
    input  logic [6:0]   seg0,
    output logic [n-1:0] value,
    output logic [2:0]   pos,
    output logic         dir,
    output logic         locked,
    output logic         step,
    output logic         dir_change,
    output logic         rate_fast,
    output logic [1:0]   err_code,
    output logic         err_sticky,
    output logic         timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        FAULT   = 2'd3
    } state_t;

    // Interval thresholds, computed in 64 bits so large clock rates cannot overflow.
    localparam logic [31:0] RATE_THR = 32'((64'(fpga_f) * 64'd3) / 64'd4);
    localparam logic [31:0] TO_CYC   = 32'((64'(fpga_f) * 64'd5) / 64'd2);

    localparam int            HW       = $clog2(stable_cyc + 1) + 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(stable_cyc - 1);

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_GLYPH = 2'd1;
    localparam logic [1:0] ERR_TABLE = 2'd2;
    localparam logic [1:0] ERR_JUMP  = 2'd3;

    // Hex glyph decoder, active-low {g,f,e,d,c,b,a}; returns {valid, digit}.
    function automatic logic [4:0] glyph_decode(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    // Ring table of tracked values.
    function automatic logic [7:0] tbl_val(input logic [2:0] idx);
        logic [7:0] r;
        case (idx)
            3'd0:    r = 8'd5;
            3'd1:    r = 8'd10;
            3'd2:    r = 8'd15;
            3'd3:    r = 8'd4;
            3'd4:    r = 8'd9;
            3'd5:    r = 8'd14;
            3'd6:    r = 8'd3;
            3'd7:    r = 8'd8;
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    // Reverse lookup; returns {found, index}. Table entries are distinct.
    function automatic logic [3:0] tbl_find(input logic [7:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 8; i++) begin
            r = (tbl_val(3'(i)) == v) ? {1'b1, 3'(i)} : r;
        end
        return r;
    endfunction

    // Registers
    state_t        state_q, state_d;
    logic [13:0]   samp_q, samp_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          acc_valid_q, acc_valid_d;
    logic [13:0]   acc_pat_q, acc_pat_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          anchor_q, anchor_d;
    logic [n-1:0]  value_q, value_d;
    logic [2:0]    pos_q, pos_d;
    logic          dir_q, dir_d;
    logic          locked_q, locked_d;
    logic          step_q, step_d;
    logic          dchg_q, dchg_d;
    logic          rate_q, rate_d;
    logic [1:0]    err_q, err_d;
    logic          sticky_q, sticky_d;
    logic          tmo_q, tmo_d;

    // Combinational helpers
    logic          accept_s;
    logic [4:0]    tens_s, units_s;
    logic [7:0]    val_s;
    logic          dec_ok_s;
    logic [3:0]    find_s;
    state_t        eff_s;

    // Sample the glyph pair and count how long it has stayed unchanged.
    always_comb begin
        samp_d      = {seg1, seg0};
        hold_d      = {HW{1'b0}};
        acc_valid_d = acc_valid_q;
        acc_pat_d   = acc_pat_q;
        if (samp_d == samp_q) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + {{(HW-1){1'b0}}, 1'b1};
        end else begin
            hold_d = {HW{1'b0}};
        end
        accept_s = (hold_q == HOLD_MAX) && (!acc_valid_q || (samp_q != acc_pat_q));
        if (accept_s) begin
            acc_valid_d = 1'b1;
            acc_pat_d   = samp_q;
        end else begin
            acc_pat_d   = acc_pat_q;
        end
    end

    // Decode the sampled pattern and find where it sits in the ring.
    always_comb begin
        tens_s   = glyph_decode(samp_q[13:7]);
        units_s  = glyph_decode(samp_q[6:0]);
        val_s    = ({4'd0, tens_s[3:0]} * 8'd10) + {4'd0, units_s[3:0]};
        dec_ok_s = tens_s[4] && units_s[4] && (tens_s[3:0] <= 4'd1) && (val_s <= 8'd15);
        find_s   = tbl_find(val_s);
    end

    // Saturating interval counter, restarted by every acceptance.
    always_comb begin
        if (accept_s) begin
            cnt_d = 32'd0;
        end else if (cnt_q == 32'hFFFF_FFFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Next state and outputs. FAULT behaves as its one-cycle successor so an
    // acceptance arriving during FAULT is still evaluated.
    always_comb begin
        if (state_q == FAULT) begin
            eff_s = anchor_q ? ACQUIRE : IDLE;
        end else begin
            eff_s = state_q;
        end
        state_d  = eff_s;
        anchor_d = anchor_q;
        value_d  = value_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        rate_d   = rate_q;
        err_d    = err_q;
        step_d   = 1'b0;
        dchg_d   = 1'b0;
        tmo_d    = 1'b0;

        if (accept_s) begin
            if (!dec_ok_s || !find_s[3]) begin
                // Bad glyph or value off the ring: hold value/pos, fall to IDLE.
                err_d    = dec_ok_s ? ERR_TABLE : ERR_GLYPH;
                anchor_d = 1'b0;
                state_d  = (eff_s == IDLE) ? IDLE : FAULT;
            end else begin
                case (eff_s)
                    IDLE: begin
                        state_d = ACQUIRE;
                        value_d = n'(val_s);
                        pos_d   = find_s[2:0];
                        err_d   = ERR_NONE;
                    end
                    ACQUIRE, TRACK: begin
                        value_d = n'(val_s);
                        pos_d   = find_s[2:0];
                        if (find_s[2:0] == (pos_q + 3'd1)) begin
                            state_d = TRACK;
                            dir_d   = 1'b1;
                            step_d  = 1'b1;
                            dchg_d  = (eff_s == TRACK) && !dir_q;
                            rate_d  = (cnt_q < RATE_THR);
                            err_d   = ERR_NONE;
                        end else if (find_s[2:0] == (pos_q - 3'd1)) begin
                            state_d = TRACK;
                            dir_d   = 1'b0;
                            step_d  = 1'b1;
                            dchg_d  = (eff_s == TRACK) && dir_q;
                            rate_d  = (cnt_q < RATE_THR);
                            err_d   = ERR_NONE;
                        end else begin
                            // Legal ring value but not a neighbour: re-anchor on it.
                            state_d  = FAULT;
                            anchor_d = 1'b1;
                            err_d    = ERR_JUMP;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end else if (((eff_s == ACQUIRE) || (eff_s == TRACK)) && (cnt_q >= TO_CYC)) begin
            tmo_d   = 1'b1;
            state_d = IDLE;
        end else begin
            tmo_d   = 1'b0;
        end

        sticky_d = sticky_q || (err_d != ERR_NONE);
        locked_d = (state_d == TRACK);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            samp_q      <= 14'h3FFF;
            hold_q      <= {HW{1'b0}};
            acc_valid_q <= 1'b0;
            acc_pat_q   <= 14'h0000;
            cnt_q       <= 32'd0;
            anchor_q    <= 1'b0;
            value_q     <= {n{1'b0}};
            pos_q       <= 3'd0;
            dir_q       <= 1'b1;
            locked_q    <= 1'b0;
            step_q      <= 1'b0;
            dchg_q      <= 1'b0;
            rate_q      <= 1'b0;
            err_q       <= 2'd0;
            sticky_q    <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            hold_q      <= hold_d;
            acc_valid_q <= acc_valid_d;
            acc_pat_q   <= acc_pat_d;
            cnt_q       <= cnt_d;
            anchor_q    <= anchor_d;
            value_q     <= value_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            locked_q    <= locked_d;
            step_q      <= step_d;
            dchg_q      <= dchg_d;
            rate_q      <= rate_d;
            err_q       <= err_d;
            sticky_q    <= sticky_d;
            tmo_q       <= tmo_d;
        end
    end

    assign value      = value_q;
    assign pos        = pos_q;
    assign dir        = dir_q;
    assign locked     = locked_q;
    assign step       = step_q;
    assign dir_change = dchg_q;
    assign rate_fast  = rate_q;
    assign err_code   = err_q;
    assign err_sticky = sticky_q;
    assign timeout    = tmo_q;

endmodule

// File: tb/tb_seq_display_monitor.sv
// Directed bench for seq_display_monitor (fpga_f=1000, stable_cyc=4:
// rate threshold 750 cycles, timeout 2500 cycles).
// Observed outputs are packed as
// {value[3:0], pos[2:0], dir, locked, step, dir_change, rate_fast, err_code[1:0], err_sticky, timeout}.

module tb_seq_display_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg1, seg0;
    logic [3:0] value;
    logic [2:0] pos;
    logic       dir, locked, step, dir_change, rate_fast, err_sticky, timeout;
    logic [1:0] err_code;

    logic [15:0] obs;
    logic [15:0] exp_v;
    int checks = 0;
    int errors = 0;
    int elapsed = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seq_display_monitor #(.fpga_f(1000), .n(4), .stable_cyc(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .seg1       (seg1),
        .seg0       (seg0),
        .value      (value),
        .pos        (pos),
        .dir        (dir),
        .locked     (locked),
        .step       (step),
        .dir_change (dir_change),
        .rate_fast  (rate_fast),
        .err_code   (err_code),
        .err_sticky (err_sticky),
        .timeout    (timeout)
    );

    assign obs = {value, pos, dir, locked, step, dir_change, rate_fast, err_code, err_sticky, timeout};

    // Advance k rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Drive a two-digit number; negative means both digits blank.
    task automatic set_val(input int v);
        if (v < 0) begin
            seg1 = 7'h7F;
            seg0 = 7'h7F;
        end else begin
            seg1 = glyph[v / 10];
            seg0 = glyph[v % 10];
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_val(5);
        tick(3);
        exp_v = {4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_hold got=%h want=%h", obs, exp_v); end
        reset = 1'b0;
        tick(4);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pre_accept got=%h want=%h", obs, exp_v); end
        tick(1);
        exp_v = {4'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL acquire_05 got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_up_sweep;
        int vals [8] = '{10, 15, 4, 9, 14, 3, 8, 5};
        tick(495);
        for (int i = 0; i < 8; i++) begin
            set_val(vals[i]);
            tick(5);
            exp_v = {4'(vals[i]), 3'((i + 1) % 8), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL up_step_%0d got=%h want=%h", i, obs, exp_v); end
            tick(1);
            exp_v = {4'(vals[i]), 3'((i + 1) % 8), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL up_pulse_%0d got=%h want=%h", i, obs, exp_v); end
            tick(494);
        end
    endtask

    task automatic test_reverse;
        tick(500);
        set_val(8);
        tick(5);
        exp_v = {4'd8, 3'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL down_wrap got=%h want=%h", obs, exp_v); end
        tick(495);
        set_val(5);
        tick(5);
        exp_v = {4'd5, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL up_reverse got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_fault;
        int vals [6] = '{7, -1, 6, 16, 12, 20};
        logic [1:0] errs [6] = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
        tick(495);
        set_val(15);
        tick(5);
        exp_v = {4'd15, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL jump_fault got=%h want=%h", obs, exp_v); end
        tick(5);
        for (int i = 0; i < 6; i++) begin
            set_val(vals[i]);
            tick(5);
            exp_v = {4'd15, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, errs[i], 1'b1, 1'b0};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL bad_value_%0d got=%h want=%h", i, obs, exp_v); end
        end
        set_val(10);
        tick(5);
        exp_v = {4'd10, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL idle_load got=%h want=%h", obs, exp_v); end
        set_val(15);
        tick(5);
        exp_v = {4'd15, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL acq_step got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_glitch;
        set_val(4);
        tick(5);
        exp_v = {4'd4, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL step_to_4 got=%h want=%h", obs, exp_v); end
        elapsed = 0;
        set_val(9);
        tick(2);
        set_val(4);
        tick(10);
        elapsed = 12;
        exp_v = {4'd4, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL glitch_ignored got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_timeout;
        for (int i = 0; i < 3000; i++) begin
            if (timeout !== 1'b1) begin
                tick(1);
                elapsed++;
            end
        end
        checks++;
        if (elapsed != 2501) begin errors++; $display("FAIL timeout_latency got=%0d want=2501", elapsed); end
        exp_v = {4'd4, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL timeout_state got=%h want=%h", obs, exp_v); end
        tick(1);
        exp_v = {4'd4, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL timeout_pulse got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_accept_wins;
        set_val(9);
        tick(5);
        exp_v = {4'd9, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL idle_reacquire got=%h want=%h", obs, exp_v); end
        tick(2496);
        set_val(14);
        tick(5);
        exp_v = {4'd14, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL accept_vs_timeout got=%h want=%h", obs, exp_v); end
        tick(1);
        exp_v = {4'd14, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL after_tie got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        tick(1);
        exp_v = {4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mid_reset got=%h want=%h", obs, exp_v); end
        reset = 1'b0;
        tick(5);
        exp_v = {4'd14, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL post_reset_new got=%h want=%h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_up_sweep();
        test_reverse();
        test_fault();
        test_glitch();
        test_timeout();
        test_accept_wins();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
